alu_issue_queue: RTL and testbench

- In-order issue buffer that is the producer side of the ALU operand interface.
- Accepts decoded ALU micro-ops from dispatch and holds them until both source operands are available.
- Snoops the result broadcast bus (CDB) to capture late operands.
- Presents the oldest op, with resolved A/B operands and control fields, to the ALU issue port under a valid/ready handshake.

---
 rtl/alu_iq_pkg.sv | 37 +++
 rtl/alu_iq_operand.sv | 54 +++++
 rtl/alu_issue_queue.sv | 137 +++++++++++++
 tb/tb_alu_issue_queue.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iq_pkg.sv
// Shared types for the ALU issue queue: ALU op codes, operand slot and entry layout.
// The struct widths follow the default tag/operand widths of the queue.
package alu_iq_pkg;

   localparam int IQ_TAG_W = 6;
   localparam int IQ_XLEN  = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLL  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_CTZ  = 4'b1010,
      ALU_CLZ  = 4'b1011,
      ALU_CPOP = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic                rdy;
      logic [IQ_TAG_W-1:0] tag;
      logic [IQ_XLEN-1:0]  val;
   } iq_src_t;

   typedef struct packed {
      logic                valid;
      alu_op_e             op;
      logic                mode;
      iq_src_t             src1;
      iq_src_t             src2;
      logic [IQ_TAG_W-1:0] dst_tag;
   } iq_entry_t;

endpackage

// File: rtl/alu_iq_operand.sv
// One source-operand capture slot: loads at dispatch (with same-cycle CDB bypass)
// and wakes up from the result broadcast while its entry is valid.
module alu_iq_operand #(
   parameter int TAG_W = 6,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             entry_valid,
   input  logic             load,
   input  logic             load_rdy,
   input  logic [TAG_W-1:0] load_tag,
   input  logic [XLEN-1:0]  load_val,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output logic             rdy,
   output logic [XLEN-1:0]  val
);

   logic [TAG_W-1:0] tag;
   logic             hit_load;
   logic             hit_wake;

   assign hit_load = cdb_valid && (cdb_tag == load_tag);
   assign hit_wake = entry_valid && !rdy && cdb_valid && (cdb_tag == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy <= 1'b0;
         tag <= '0;
         val <= '0;
      end else if (!clear) begin
         if (load) begin
            tag <= load_tag;
            if (load_rdy) begin
               rdy <= 1'b1;
               val <= load_val;
            end else if (hit_load) begin
               rdy <= 1'b1;
               val <= cdb_data;
            end else begin
               rdy <= 1'b0;
               val <= '0;
            end
         end else if (hit_wake) begin
            rdy <= 1'b1;
            val <= cdb_data;
         end
      end
   end

endmodule

// File: rtl/alu_issue_queue.sv
// In-order ALU issue buffer: circular FIFO of decoded ops that waits for both
// operands (snooping the CDB) and presents the oldest op on a valid/ready port.
module alu_issue_queue
   import alu_iq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = IQ_TAG_W,
   parameter int XLEN  = IQ_XLEN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         disp_valid,
   output logic                         disp_ready,
   input  logic [3:0]                   disp_alu_control,
   input  logic                         disp_add_sub_mode,
   input  logic                         disp_src1_rdy,
   input  logic                         disp_src2_rdy,
   input  logic [XLEN-1:0]              disp_src1_val,
   input  logic [XLEN-1:0]              disp_src2_val,
   input  logic [TAG_W-1:0]             disp_src1_tag,
   input  logic [TAG_W-1:0]             disp_src2_tag,
   input  logic [TAG_W-1:0]             disp_dst_tag,
   input  logic                         cdb_valid,
   input  logic [TAG_W-1:0]             cdb_tag,
   input  logic [XLEN-1:0]              cdb_data,
   output logic                         iss_valid,
   input  logic                         iss_ready,
   output logic [XLEN-1:0]              iss_A,
   output logic [XLEN-1:0]              iss_B,
   output logic [3:0]                   iss_alu_control,
   output logic                         iss_add_sub_mode,
   output logic [TAG_W-1:0]             iss_dst_tag,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] mode_q;
   alu_op_e          op_q   [DEPTH];
   logic [TAG_W-1:0] dst_q  [DEPTH];
   logic [DEPTH-1:0] s1_rdy;
   logic [DEPTH-1:0] s2_rdy;
   logic [XLEN-1:0]  s1_val [DEPTH];
   logic [XLEN-1:0]  s2_val [DEPTH];
   iq_entry_t        disp_e;
   logic             push;
   logic             pop;
   logic             head_vld;

   // Flush wins over both push and pop for the cycle it is asserted.
   assign disp_ready = (count != CNT_W'(DEPTH));
   assign push       = disp_valid && disp_ready && !flush;
   assign pop        = iss_valid && iss_ready && !flush;

   always_comb begin
      disp_e           = '0;
      disp_e.valid     = push;
      disp_e.op        = alu_op_e'(disp_alu_control);
      disp_e.mode      = disp_add_sub_mode;
      disp_e.src1.rdy  = disp_src1_rdy;
      disp_e.src1.tag  = disp_src1_tag;
      disp_e.src1.val  = disp_src1_val;
      disp_e.src2.rdy  = disp_src2_rdy;
      disp_e.src2.tag  = disp_src2_tag;
      disp_e.src2.val  = disp_src2_val;
      disp_e.dst_tag   = disp_dst_tag;
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      logic load;
      assign load = disp_e.valid && (tail == PTR_W'(i));

      alu_iq_operand #(.TAG_W(TAG_W), .XLEN(XLEN)) u_src1 (
         .clk(clk), .rst(rst), .clear(flush), .entry_valid(vld[i]), .load(load),
         .load_rdy(disp_e.src1.rdy), .load_tag(disp_e.src1.tag), .load_val(disp_e.src1.val),
         .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
         .rdy(s1_rdy[i]), .val(s1_val[i])
      );

      alu_iq_operand #(.TAG_W(TAG_W), .XLEN(XLEN)) u_src2 (
         .clk(clk), .rst(rst), .clear(flush), .entry_valid(vld[i]), .load(load),
         .load_rdy(disp_e.src2.rdy), .load_tag(disp_e.src2.tag), .load_val(disp_e.src2.val),
         .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
         .rdy(s2_rdy[i]), .val(s2_val[i])
      );
   end

   // A push targets an empty slot, so push and pop never touch the same entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld    <= '0;
         mode_q <= '0;
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= ALU_ADD;
            dst_q[i] <= '0;
         end
      end else if (flush) begin
         vld   <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            vld[tail]    <= 1'b1;
            op_q[tail]   <= disp_e.op;
            mode_q[tail] <= disp_e.mode;
            dst_q[tail]  <= disp_e.dst_tag;
            tail         <= tail + PTR_W'(1);
         end
         if (pop) begin
            vld[head] <= 1'b0;
            head      <= head + PTR_W'(1);
         end
         if (push && !pop)
            count <= count + CNT_W'(1);
         else if (!push && pop)
            count <= count - CNT_W'(1);
      end
   end

   assign head_vld         = vld[head];
   assign iss_valid        = head_vld && s1_rdy[head] && s2_rdy[head];
   assign iss_A            = head_vld ? s1_val[head] : '0;
   assign iss_B            = head_vld ? s2_val[head] : '0;
   assign iss_alu_control  = head_vld ? op_q[head] : 4'b0000;
   assign iss_add_sub_mode = head_vld ? mode_q[head] : 1'b0;
   assign iss_dst_tag      = head_vld ? dst_q[head] : '0;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a queue-level reference model predicts the
// issue stream; a negedge monitor compares it against the DUT issue port.
module tb_alu_issue_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        disp_valid = 1'b0;
   logic        disp_ready;
   logic [3:0]  disp_alu_control = '0;
   logic        disp_add_sub_mode = 1'b0;
   logic        disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
   logic [31:0] disp_src1_val = '0, disp_src2_val = '0;
   logic [5:0]  disp_src1_tag = '0, disp_src2_tag = '0, disp_dst_tag = '0;
   logic        cdb_valid = 1'b0;
   logic [5:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        iss_valid;
   logic        iss_ready = 1'b0;
   logic [31:0] iss_A, iss_B;
   logic [3:0]  iss_alu_control;
   logic        iss_add_sub_mode;
   logic [5:0]  iss_dst_tag;
   logic [2:0]  count;

   alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_alu_control(disp_alu_control), .disp_add_sub_mode(disp_add_sub_mode),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_src1_val(disp_src1_val), .disp_src2_val(disp_src2_val),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_dst_tag(disp_dst_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_A(iss_A), .iss_B(iss_B), .iss_alu_control(iss_alu_control),
      .iss_add_sub_mode(iss_add_sub_mode), .iss_dst_tag(iss_dst_tag),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic        mode;
      logic        r1, r2;
      logic [5:0]  t1, t2;
      logic [31:0] v1, v2;
      logic [5:0]  dst;
   } op_t;

   op_t mq[$];      // dispatched ops still waiting behind a non-ready op
   op_t exp_q[$];   // in-order ops that are issuable, oldest first
   int  pop_pend = 0;
   int  n_cmp = 0;
   int  n_bad = 0;

   logic [3:0] codes [11] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hA, 4'hB, 4'hC};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: applies the queue rules at each clock edge.
   initial begin : model
      op_t e;
      int  occ;
      forever begin
         @(posedge clk or posedge rst);
         if (rst || flush) begin
            mq.delete();
            exp_q.delete();
            pop_pend = 0;
         end else begin
            occ = mq.size() + exp_q.size() + pop_pend;
            pop_pend = 0;
            for (int i = 0; i < mq.size(); i++) begin
               e = mq[i];
               if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
               if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
               mq[i] = e;
            end
            if (disp_valid && occ < DEPTH) begin
               e.op = disp_alu_control; e.mode = disp_add_sub_mode; e.dst = disp_dst_tag;
               e.r1 = disp_src1_rdy; e.t1 = disp_src1_tag; e.v1 = disp_src1_rdy ? disp_src1_val : 32'h0;
               e.r2 = disp_src2_rdy; e.t2 = disp_src2_tag; e.v2 = disp_src2_rdy ? disp_src2_val : 32'h0;
               if (cdb_valid && !e.r1 && e.t1 == cdb_tag) begin e.r1 = 1'b1; e.v1 = cdb_data; end
               if (cdb_valid && !e.r2 && e.t2 == cdb_tag) begin e.r2 = 1'b1; e.v2 = cdb_data; end
               mq.push_back(e);
            end
            while (mq.size() > 0 && mq[0].r1 && mq[0].r2)
               exp_q.push_back(mq.pop_front());
         end
      end
   end

   // Monitor: compares the issue port against the scoreboard every cycle.
   initial begin : monitor
      op_t e;
      int  occ;
      forever begin
         @(negedge clk);
         if (!rst) begin
            occ = mq.size() + exp_q.size();
            chk("count", 64'(count), 64'(occ));
            chk("disp_ready", 64'(disp_ready), 64'(occ < DEPTH));
            chk("iss_valid", 64'(iss_valid), 64'(exp_q.size() != 0));
            if (occ == 0) chk("iss_A_idle", 64'(iss_A), 64'h0);
            if (iss_valid && exp_q.size() != 0) begin
               e = exp_q[0];
               chk("iss_A", 64'(iss_A), 64'(e.v1));
               chk("iss_B", 64'(iss_B), 64'(e.v2));
               chk("iss_alu_control", 64'(iss_alu_control), 64'(e.op));
               chk("iss_add_sub_mode", 64'(iss_add_sub_mode), 64'(e.mode));
               chk("iss_dst_tag", 64'(iss_dst_tag), 64'(e.dst));
               if (iss_ready) begin
                  void'(exp_q.pop_front());
                  pop_pend = 1;
               end
            end
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic disp(input logic [3:0] op, input logic mode,
                       input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                       input logic r2, input logic [5:0] t2, input logic [31:0] v2,
                       input logic [5:0] dst);
      disp_valid = 1'b1; disp_alu_control = op; disp_add_sub_mode = mode;
      disp_src1_rdy = r1; disp_src1_tag = t1; disp_src1_val = v1;
      disp_src2_rdy = r2; disp_src2_tag = t2; disp_src2_val = v2;
      disp_dst_tag = dst;
   endtask

   task automatic bcast(input logic [5:0] t, input logic [31:0] d);
      cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
   endtask

   initial begin
      step(2);
      chk("rst_iss_valid", 64'(iss_valid), 64'h0);
      chk("rst_disp_ready", 64'(disp_ready), 64'h1);
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_iss_A", 64'(iss_A), 64'h0);
      rst = 1'b0;
      step(2);

      // ADD, both operands ready
      iss_ready = 1'b1;
      disp(4'h0, 1'b0, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7, 6'd1);
      step(); disp_valid = 1'b0;
      step(3);

      // SUB waiting on tag 3, broadcast two cycles later
      disp(4'h1, 1'b1, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'd10, 6'd2);
      step(); disp_valid = 1'b0;
      step();
      bcast(6'd3, 32'd25);
      step(); cdb_valid = 1'b0;
      step(3);

      // Fill, then drain in order with a wrapping fifth dispatch
      iss_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         disp(codes[i+2], 1'b0, 1'b1, 6'd0, 32'(100 + i), 1'b1, 6'd0, 32'(200 + i), 6'(10 + i));
         step();
      end
      disp_valid = 1'b0;
      chk("full_count", 64'(count), 64'd4);
      chk("full_disp_ready", 64'(disp_ready), 64'h0);
      iss_ready = 1'b1;
      disp(4'hC, 1'b0, 1'b1, 6'd0, 32'd555, 1'b1, 6'd0, 32'd666, 6'd20);
      step(2); disp_valid = 1'b0;
      step(6);

      // Non-ready head blocks a ready younger op
      disp(4'h4, 1'b0, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'd1, 6'd30);
      step();
      disp(4'h5, 1'b0, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 32'd3, 6'd31);
      step(); disp_valid = 1'b0;
      step(3);
      chk("blocked_count", 64'(count), 64'd2);
      chk("blocked_iss_valid", 64'(iss_valid), 64'h0);
      bcast(6'd9, 32'hDEAD_BEEF);
      step(); cdb_valid = 1'b0;
      step(4);

      // Flush with a simultaneous dispatch
      iss_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         disp(4'h2, 1'b0, 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 32'(i), 6'(40 + i));
         step();
      end
      flush = 1'b1;
      disp(4'h3, 1'b0, 1'b1, 6'd0, 32'd9, 1'b1, 6'd0, 32'd9, 6'd50);
      step(); flush = 1'b0; disp_valid = 1'b0;
      chk("flush_count", 64'(count), 64'h0);
      chk("flush_iss_valid", 64'(iss_valid), 64'h0);
      step(2);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         disp_valid        = 1'($urandom_range(0, 1));
         disp_alu_control  = codes[$urandom_range(0, 10)];
         disp_add_sub_mode = 1'($urandom_range(0, 1));
         disp_src1_rdy     = 1'($urandom_range(0, 1));
         disp_src2_rdy     = 1'($urandom_range(0, 1));
         disp_src1_tag     = 6'($urandom_range(0, 7));
         disp_src2_tag     = 6'($urandom_range(0, 7));
         disp_src1_val     = $urandom;
         disp_src2_val     = $urandom;
         disp_dst_tag      = 6'($urandom_range(0, 63));
         cdb_valid         = ($urandom_range(0, 2) == 0);
         cdb_tag           = 6'($urandom_range(0, 7));
         cdb_data          = $urandom;
         flush             = ($urandom_range(0, 99) == 0);
         iss_ready         = flush ? 1'b0 : 1'($urandom_range(0, 1));
         step();
      end
      flush = 1'b0; cdb_valid = 1'b0;

      // Asynchronous reset in the middle of traffic
      iss_ready = 1'b0;
      disp(4'h0, 1'b0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 6'd3);
      step(2); disp_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_count", 64'(count), 64'h0);
      chk("async_rst_iss_valid", 64'(iss_valid), 64'h0);
      step(2);
      rst = 1'b0;
      iss_ready = 1'b1;
      disp(4'h7, 1'b1, 1'b1, 6'd0, 32'd77, 1'b1, 6'd0, 32'd88, 6'd5);
      step(); disp_valid = 1'b0;
      step(4);
      chk("drain_count", 64'(count), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
